// File: rtl/reg_dump_reader.sv
// Debug read-side client of the register file: sweeps an inclusive, wrapping
// address range over one read port and streams (address, value) words to a host.
module reg_dump_reader #(
    parameter int DW = 32,
    parameter int AW = 5
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          Start,
    input  logic          Abort,
    input  logic [AW-1:0] StartAddr,
    input  logic [AW-1:0] EndAddr,
    output logic [AW-1:0] RAddr,
    output logic          RdEn,
    input  logic [DW-1:0] RData,
    output logic [DW-1:0] OutData,
    output logic [AW-1:0] OutAddr,
    output logic          OutValid,
    input  logic          OutReady,
    output logic          Busy,
    output logic          Done,
    output logic [2:0]    DbgState
);

    // Handshake: a word moves on any rising edge where OutValid and OutReady are
    // both high; OutData/OutAddr stay frozen while OutValid waits for OutReady.
    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_READ = 3'd1,
        S_WAIT = 3'd2,
        S_SEND = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t        r_state;
    state_t        w_next_state;
    logic [AW-1:0] r_cur;
    logic [AW-1:0] w_cur;
    logic [AW-1:0] r_end;
    logic [AW-1:0] w_end;
    logic [AW-1:0] r_raddr;
    logic [AW-1:0] w_raddr;
    logic [AW-1:0] r_out_addr;
    logic [AW-1:0] w_out_addr;
    logic [DW-1:0] r_out_data;
    logic [DW-1:0] w_out_data;
    logic          r_rd_en;
    logic          w_rd_en;
    logic          r_out_valid;
    logic          w_out_valid;
    logic          r_busy;
    logic          w_busy;
    logic          r_done;
    logic          w_done;
    logic          w_abort;
    logic          w_xfer;
    logic          w_last;

    assign w_abort = Abort && (r_state != S_IDLE);
    assign w_xfer  = (r_state == S_SEND) && r_out_valid && OutReady;
    assign w_last  = (r_cur == r_end);

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_state     <= S_IDLE;
            r_cur       <= '0;
            r_end       <= '0;
            r_raddr     <= '0;
            r_rd_en     <= 1'b0;
            r_out_data  <= '0;
            r_out_addr  <= '0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_next_state;
            r_cur       <= w_cur;
            r_end       <= w_end;
            r_raddr     <= w_raddr;
            r_rd_en     <= w_rd_en;
            r_out_data  <= w_out_data;
            r_out_addr  <= w_out_addr;
            r_out_valid <= w_out_valid;
            r_busy      <= w_busy;
            r_done      <= w_done;
        end
    end

    always_comb begin
        w_next_state = r_state;
        if (w_abort) begin
            w_next_state = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: if (Start && !Abort) w_next_state = S_READ;
                S_READ: w_next_state = S_WAIT;
                S_WAIT: w_next_state = S_SEND;
                S_SEND: if (w_xfer) w_next_state = w_last ? S_DONE : S_READ;
                S_DONE: w_next_state = S_IDLE;
                default: w_next_state = S_IDLE;
            endcase
        end
    end

    // Registered outputs are loaded with the values that belong to the state
    // being entered, so every output is valid for the whole of that state.
    always_comb begin
        w_cur       = r_cur;
        w_end       = r_end;
        w_raddr     = r_raddr;
        w_out_data  = r_out_data;
        w_out_addr  = r_out_addr;
        w_rd_en     = (w_next_state == S_READ) || (w_next_state == S_WAIT);
        w_out_valid = (w_next_state == S_SEND);
        w_busy      = (w_next_state != S_IDLE);
        w_done      = (w_next_state == S_DONE);
        if (r_state == S_IDLE && w_next_state == S_READ) begin
            w_cur   = StartAddr;
            w_end   = EndAddr;
            w_raddr = StartAddr;
        end
        // x0 has no storage behind it, so its read data is never trusted.
        if (r_state == S_WAIT && w_next_state == S_SEND) begin
            w_out_data = (r_cur == '0) ? '0 : RData;
            w_out_addr = r_cur;
        end
        if (r_state == S_SEND && w_next_state == S_READ) begin
            w_cur   = r_cur + 1'b1;
            w_raddr = r_cur + 1'b1;
        end
    end

    assign RAddr    = r_raddr;
    assign RdEn     = r_rd_en;
    assign OutData  = r_out_data;
    assign OutAddr  = r_out_addr;
    assign OutValid = r_out_valid;
    assign Busy     = r_busy;
    assign Done     = r_done;
    assign DbgState = r_state;

endmodule

// File: tb/tb_reg_dump_reader.sv
// Directed bench for reg_dump_reader: a register-file model, a queue of
// expected words derived from the sweep range, and literal timing checks.
module tb_reg_dump_reader;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int W  = AW + DW;
    localparam int NREG = 1 << AW;

    logic          Clk;
    logic          Reset;
    logic          Start;
    logic          Abort;
    logic [AW-1:0] StartAddr;
    logic [AW-1:0] EndAddr;
    logic [AW-1:0] RAddr;
    logic          RdEn;
    logic [DW-1:0] RData;
    logic [DW-1:0] OutData;
    logic [AW-1:0] OutAddr;
    logic          OutValid;
    logic          OutReady;
    logic          Busy;
    logic          Done;
    logic [2:0]    DbgState;

    logic [DW-1:0] rf [NREG];
    logic [W-1:0]  exp_q [$];
    logic [W-1:0]  seen_q [$];
    int            n_checks;
    int            n_errors;
    int            done_cnt;

    reg_dump_reader #(.DW(DW), .AW(AW)) dut (
        .Clk(Clk), .Reset(Reset), .Start(Start), .Abort(Abort),
        .StartAddr(StartAddr), .EndAddr(EndAddr),
        .RAddr(RAddr), .RdEn(RdEn), .RData(RData),
        .OutData(OutData), .OutAddr(OutAddr), .OutValid(OutValid),
        .OutReady(OutReady), .Busy(Busy), .Done(Done), .DbgState(DbgState)
    );

    // clock / reset
    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // synchronous-read register file: data appears the cycle after RAddr
    always @(posedge Clk) RData <= rf[RAddr];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // model: the words a sweep must deliver, in order
    task automatic model_push(input int s, input int e);
        int n;
        int a;
        logic [DW-1:0] d;
        n = (((e - s) % NREG) + NREG) % NREG + 1;
        for (int i = 0; i < n; i++) begin
            a = (s + i) % NREG;
            d = (a == 0) ? '0 : rf[a];
            exp_q.push_back({a[AW-1:0], d});
        end
    endtask

    task automatic start_sweep(input int s, input int e);
        StartAddr = s[AW-1:0];
        EndAddr   = e[AW-1:0];
        Start     = 1'b1;
        model_push(s, e);
        @(negedge Clk);
        Start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        bit got;
        got = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (Done) begin
                got = 1'b1;
                break;
            end
            @(negedge Clk);
        end
        chk("done_timeout", got, 1'b1);
    endtask

    // scoreboard: every presented word must match the head of the queue
    always @(negedge Clk) begin
        if (Reset && OutValid) begin
            if (exp_q.size() == 0) chk("unexpected_word", {OutAddr, OutData}, '1);
            else                   chk("word", {OutAddr, OutData}, exp_q[0]);
        end
        if (Reset && Done) begin
            done_cnt++;
            chk("done_with_words_left", exp_q.size(), 0);
        end
    end

    always @(posedge Clk) begin
        if (Reset && OutValid && OutReady) begin
            seen_q.push_back({OutAddr, OutData});
            if (exp_q.size() != 0) void'(exp_q.pop_front());
        end
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [11:0] vmask;
        logic [11:0] dmask;
        logic [11:0] bmask;
        logic [12:0] dmask4;
        int          vcnt;
        bit          act;
        bit          seen_valid;

        n_checks = 0;
        n_errors = 0;
        done_cnt = 0;
        Reset = 1'b0;
        Start = 1'b0;
        Abort = 1'b0;
        StartAddr = '0;
        EndAddr = '0;
        OutReady = 1'b0;
        for (int i = 0; i < NREG; i++) rf[i] = 32'hA500_0000 | (i * 32'h0001_0101);
        rf[3] = 32'h11;
        rf[4] = 32'h22;
        rf[5] = 32'h33;

        // reset state
        @(negedge Clk);
        chk("reset_outputs", {RAddr, RdEn, OutData, OutAddr, OutValid, Busy, Done}, '0);
        @(negedge Clk);
        Reset = 1'b1;
        @(negedge Clk);

        // reset asserted while a word waits in SEND (Cur=7)
        start_sweep(7, 7);
        seen_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (OutValid) begin
                seen_valid = 1'b1;
                break;
            end
            @(negedge Clk);
        end
        chk("t1_valid_before_reset", seen_valid, 1'b1);
        chk("t1_addr_before_reset", OutAddr, 7);
        Reset = 1'b0;
        #1;
        chk("t1_async_reset_outputs", {RAddr, RdEn, OutData, OutAddr, OutValid, Busy, Done}, '0);
        exp_q.delete();
        @(negedge Clk);
        @(negedge Clk);
        Reset = 1'b1;
        act = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge Clk);
            if (Busy || RdEn || OutValid || Done) act = 1'b1;
        end
        chk("t1_idle_after_reset", act, 1'b0);

        // 3..5 with OutReady held high: latency and throughput
        OutReady = 1'b1;
        seen_q.delete();
        start_sweep(3, 5);
        chk("t2_first_raddr", {RdEn, RAddr}, {1'b1, 5'd3});
        vmask = '0;
        dmask = '0;
        bmask = '0;
        for (int k = 0; k < 12; k++) begin
            vmask[k] = OutValid;
            dmask[k] = Done;
            bmask[k] = Busy;
            @(negedge Clk);
        end
        chk("t2_valid_cycles", vmask, 12'h124);
        chk("t2_done_cycle", dmask, 12'h200);
        chk("t2_busy_cycles", bmask, 12'h3FF);
        chk("t2_word_count", seen_q.size(), 3);
        if (seen_q.size() == 3) begin
            chk("t2_word0", seen_q[0], {5'd3, 32'h11});
            chk("t2_word1", seen_q[1], {5'd4, 32'h22});
            chk("t2_word2", seen_q[2], {5'd5, 32'h33});
        end

        // 30..1 wraps through 31 and 0; x0 storage holds garbage
        rf[0] = 32'hBAD0_BAD0;
        seen_q.delete();
        start_sweep(30, 1);
        wait_done(40);
        @(negedge Clk);
        chk("t3_word_count", seen_q.size(), 4);
        if (seen_q.size() == 4) begin
            chk("t3_addr0", seen_q[0][W-1:DW], 30);
            chk("t3_addr1", seen_q[1][W-1:DW], 31);
            chk("t3_x0_word", seen_q[2], {5'd0, 32'h0});
            chk("t3_addr3", seen_q[3][W-1:DW], 1);
        end

        // single word 9..9 with the host stalling for 5 cycles
        OutReady = 1'b0;
        seen_q.delete();
        start_sweep(9, 9);
        vcnt = 0;
        dmask4 = '0;
        for (int k = 0; k < 13; k++) begin
            if (k == 7) OutReady = 1'b1;
            vcnt += OutValid;
            dmask4[k] = Done;
            @(negedge Clk);
        end
        chk("t4_valid_cycles", vcnt, 6);
        chk("t4_done_cycle", dmask4, 13'h100);
        chk("t4_word_count", seen_q.size(), 1);
        if (seen_q.size() == 1) chk("t4_word", seen_q[0], {5'd9, rf[9]});

        // full 0..31 sweep aborted in WAIT at Cur=12; a stray Start is ignored
        OutReady = 1'b1;
        seen_q.delete();
        start_sweep(0, 31);
        for (int k = 0; k < 37; k++) begin
            Start = (k == 10);
            if (k == 10) begin
                StartAddr = 5'd20;
                EndAddr   = 5'd20;
            end
            @(negedge Clk);
        end
        Start = 1'b0;
        chk("t5_wait_cur12", {RdEn, OutValid, RAddr}, {1'b1, 1'b0, 5'd12});
        Abort = 1'b1;
        @(negedge Clk);
        Abort = 1'b0;
        chk("t5_after_abort", {OutValid, Busy, RdEn, Done}, 4'b0000);
        exp_q.delete();
        act = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge Clk);
            if (Busy || RdEn || OutValid || Done) act = 1'b1;
        end
        chk("t5_quiet_after_abort", act, 1'b0);
        chk("t5_word_count", seen_q.size(), 12);
        if (seen_q.size() == 12) chk("t5_last_addr", seen_q[11][W-1:DW], 11);

        // Start with Abort in IDLE is dropped; Start alone then works
        seen_q.delete();
        StartAddr = 5'd2;
        EndAddr   = 5'd2;
        Start = 1'b1;
        Abort = 1'b1;
        @(negedge Clk);
        Start = 1'b0;
        Abort = 1'b0;
        chk("t6_start_abort_idle", {Busy, RdEn}, 2'b00);
        @(negedge Clk);
        start_sweep(2, 2);
        chk("t6_start_alone", {Busy, RdEn, RAddr}, {1'b1, 1'b1, 5'd2});
        wait_done(20);
        @(negedge Clk);
        chk("t6_word_count", seen_q.size(), 1);
        if (seen_q.size() == 1) chk("t6_word", seen_q[0], {5'd2, rf[2]});
        chk("done_pulse_total", done_cnt, 4);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
